// File: rtl/const_mult_seq.sv
// Sequential constant multiplier: product = in_data * coef[coef_sel] mod 2^WIDTH,
// built one shift-and-add/subtract term per cycle from a fixed coefficient table.
module const_mult_seq #(
  parameter int unsigned WIDTH = 25,
  parameter int unsigned SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] coef_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [3:0]       cidx_q, cidx_d;
  logic [1:0]       idx_q, idx_d;
  logic             err_q, err_d;

  logic             sel_legal;
  logic [2:0]       t_shift;
  logic             t_sub;
  logic             t_last;
  logic [WIDTH-1:0] addend;

  assign sel_legal = (32'(coef_sel) <= 32'd10);

  // Term table: one (shift, sign) term per (coefficient, term index) pair.
  always_comb begin
    t_shift = 3'd0;
    t_sub   = 1'b0;
    t_last  = 1'b1;
    case ({cidx_q, idx_q})
      // 39 = +32 +8 -1
      {4'd0, 2'd0}:  begin t_shift = 3'd5; t_last = 1'b0; end
      {4'd0, 2'd1}:  begin t_shift = 3'd3; t_last = 1'b0; end
      {4'd0, 2'd2}:  begin t_shift = 3'd0; t_sub  = 1'b1; end
      // 36 = +32 +4
      {4'd1, 2'd0}:  begin t_shift = 3'd5; t_last = 1'b0; end
      {4'd1, 2'd1}:  begin t_shift = 3'd2; end
      // 35 = +32 +2 +1
      {4'd2, 2'd0}:  begin t_shift = 3'd5; t_last = 1'b0; end
      {4'd2, 2'd1}:  begin t_shift = 3'd1; t_last = 1'b0; end
      {4'd2, 2'd2}:  begin t_shift = 3'd0; end
      // 30 = +32 -2
      {4'd3, 2'd0}:  begin t_shift = 3'd5; t_last = 1'b0; end
      {4'd3, 2'd1}:  begin t_shift = 3'd1; t_sub  = 1'b1; end
      // 19 = +16 +2 +1
      {4'd4, 2'd0}:  begin t_shift = 3'd4; t_last = 1'b0; end
      {4'd4, 2'd1}:  begin t_shift = 3'd1; t_last = 1'b0; end
      {4'd4, 2'd2}:  begin t_shift = 3'd0; end
      // 16
      {4'd5, 2'd0}:  begin t_shift = 3'd4; end
      // 15 = +16 -1
      {4'd6, 2'd0}:  begin t_shift = 3'd4; t_last = 1'b0; end
      {4'd6, 2'd1}:  begin t_shift = 3'd0; t_sub  = 1'b1; end
      // 14 = +16 -2
      {4'd7, 2'd0}:  begin t_shift = 3'd4; t_last = 1'b0; end
      {4'd7, 2'd1}:  begin t_shift = 3'd1; t_sub  = 1'b1; end
      // 8
      {4'd8, 2'd0}:  begin t_shift = 3'd3; end
      // 6 = +4 +2
      {4'd9, 2'd0}:  begin t_shift = 3'd2; t_last = 1'b0; end
      {4'd9, 2'd1}:  begin t_shift = 3'd1; end
      // 2
      {4'd10, 2'd0}: begin t_shift = 3'd1; end
      default: ;
    endcase
  end

  assign addend = opnd_q << t_shift;

  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    cidx_d  = cidx_q;
    idx_d   = idx_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opnd_d = in_data;
          acc_d  = '0;
          idx_d  = 2'd0;
          if (sel_legal) begin
            cidx_d  = 4'(coef_sel);
            err_d   = 1'b0;
            state_d = ACC;
          end else begin
            cidx_d  = 4'd0;
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      ACC: begin
        acc_d = t_sub ? (acc_q - addend) : (acc_q + addend);
        idx_d = idx_q + 2'd1;
        if (t_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opnd_q  <= '0;
      acc_q   <= '0;
      cidx_q  <= 4'd0;
      idx_q   <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      cidx_q  <= cidx_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Outputs are forced to zero outside DONE so reset clears them without a clock.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_valid ? acc_q : '0;
  assign out_err   = out_valid & err_q;

endmodule

// File: tb/tb_const_mult_seq.sv
// Self-checking bench for const_mult_seq: directed cases, per-coefficient sweep,
// reset aborts and randomized operations against an arithmetic reference.
module tb_const_mult_seq;
  localparam int W = 25;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [3:0]   coef_sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_err;

  int checks = 0;
  int errors = 0;

  int coef[11]   = '{39, 36, 35, 30, 19, 16, 15, 14, 8, 6, 2};
  int nterms[11] = '{3, 2, 3, 2, 3, 1, 2, 2, 1, 2, 1};

  const_mult_seq #(.WIDTH(W), .SEL_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .coef_sel (coef_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_prod(input logic [W-1:0] d, input int s);
    longint p;
    p = longint'(d) * longint'(coef[s]);
    return p[W-1:0];
  endfunction

  // One full transaction: accept, latency, hold with out_ready low, consume.
  task automatic run_op(input string tag, input logic [W-1:0] d, input int s, input int hold,
                        input logic [W-1:0] exp_d, input logic exp_e, input int exp_lat);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    in_data   = d;
    coef_sel  = s[3:0];
    out_ready = 1'b0;
    @(posedge clk); #1;
    // Scramble inputs and poke in_valid while busy; none of it may matter.
    in_data  = W'($urandom);
    coef_sel = 4'($urandom);
    in_valid = 1'b1;
    lat = 1;
    while (!out_valid && lat <= 8) begin
      check({tag, " idle out_data"}, 64'(out_data), 64'd0);
      check({tag, " idle out_err"}, 64'(out_err), 64'd0);
      check({tag, " busy in_ready"}, 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      in_data = W'($urandom);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " out_valid"}, 64'(out_valid), 64'd1);
    check({tag, " out_data"}, 64'(out_data), 64'(exp_d));
    check({tag, " out_err"}, 64'(out_err), 64'(exp_e));
    check({tag, " done in_ready"}, 64'(in_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      in_data  = W'($urandom);
      coef_sel = 4'($urandom);
      @(posedge clk); #1;
      check({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
      check({tag, " hold out_data"}, 64'(out_data), 64'(exp_d));
      check({tag, " hold out_err"}, 64'(out_err), 64'(exp_e));
      check({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " post out_valid"}, 64'(out_valid), 64'd0);
    check({tag, " post in_ready"}, 64'(in_ready), 64'd1);
    check({tag, " post out_data"}, 64'(out_data), 64'd0);
  endtask

  initial begin
    logic [W-1:0] d;
    int           s;
    int           hold;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    coef_sel  = '0;
    out_ready = 1'b0;
    #3;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
    check("reset out_err", 64'(out_err), 64'd0);
    #9 rst_n = 1'b1;
    check("reset in_ready", 64'(in_ready), 64'd1);

    // Directed cases; the first is accepted on the first edge after release.
    run_op("sel0_100", 25'd100, 0, 0, 25'd3900, 1'b0, 4);
    run_op("sel3_neg3", 25'h1FFFFFD, 3, 0, 25'h1FFFFA6, 1'b0, 3);
    run_op("sel10_wrap", 25'h0FFFFFF, 10, 0, 25'h1FFFFFE, 1'b0, 2);
    run_op("sel12_illegal", 25'd5, 12, 0, 25'd0, 1'b1, 1);
    run_op("hold5", 25'd1234, 4, 5, ref_prod(25'd1234, 4), 1'b0, 4);

    for (int i = 0; i <= 10; i++) begin
      d = W'($urandom);
      run_op($sformatf("sweep%0d", i), d, i, 0, ref_prod(d, i), 1'b0, nterms[i] + 1);
    end

    // Reset during ACC aborts the operation.
    in_valid = 1'b1;
    in_data  = 25'd777;
    coef_sel = 4'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_acc out_valid", 64'(out_valid), 64'd0);
    check("rst_acc out_data", 64'(out_data), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("rst_acc no result", 64'(out_valid), 64'd0);
      check("rst_acc in_ready", 64'(in_ready), 64'd1);
    end

    // Reset during DONE clears outputs immediately.
    in_valid = 1'b1;
    in_data  = 25'd9;
    coef_sel = 4'd15;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst_done pre out_err", 64'(out_err), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_done out_err", 64'(out_err), 64'd0);
    check("rst_done out_valid", 64'(out_valid), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_done no result", 64'(out_valid), 64'd0);
    run_op("after_rst", 25'd100, 0, 1, 25'd3900, 1'b0, 4);

    for (int i = 0; i < 40; i++) begin
      d    = W'($urandom);
      s    = int'($urandom_range(0, 15));
      hold = int'($urandom_range(0, 3));
      if (s > 10) run_op($sformatf("rand%0d", i), d, s, hold, 25'd0, 1'b1, 1);
      else run_op($sformatf("rand%0d", i), d, s, hold, ref_prod(d, s), 1'b0, nterms[s] + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
